// File: rtl/wb_peripheral_bridge.sv
// Wishbone classic slave that turns each request into one peripheral-bus access.
// The access stretches while the responder is busy and gives up with an error after a bounded wait.
module wb_peripheral_bridge #(
    parameter int ADDRESS_WIDTH  = 24,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    input  logic [3:0]               wb_sel_i,
    input  logic [ADDRESS_WIDTH-1:0] wb_adr_i,
    input  logic [31:0]              wb_data_i,
    output logic                     wb_ack_o,
    output logic                     wb_error_o,
    output logic [31:0]              wb_data_o,
    output logic                     peripheralBus_we,
    output logic                     peripheralBus_oe,
    output logic [ADDRESS_WIDTH-1:0] peripheralBus_address,
    output logic [3:0]               peripheralBus_byteSelect,
    output logic [31:0]              peripheralBus_dataWrite,
    input  logic                     peripheralBus_busy,
    input  logic [31:0]              peripheralBus_dataRead,
    input  logic                     requestOutput
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]               state_q,   state_d;
    logic [7:0]               counter_q, counter_d;
    logic                     we_q,      we_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [3:0]               sel_q,     sel_d;
    logic [31:0]              wdata_q,   wdata_d;
    logic [31:0]              rdata_q,   rdata_d;
    logic                     ack_q,     ack_d;
    logic                     error_q,   error_d;

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        we_d      = we_q;
        address_d = address_q;
        sel_d     = sel_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ack_d     = 1'b0;
        error_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    we_d      = wb_we_i;
                    address_d = wb_adr_i;
                    sel_d     = wb_sel_i;
                    wdata_d   = wb_data_i;
                    counter_d = 8'd0;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                // A master abort wins over a completion in the same cycle.
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (!peripheralBus_busy) begin
                    state_d = RESPOND;
                    if (we_q) begin
                        ack_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else if (requestOutput) begin
                        ack_d   = 1'b1;
                        rdata_d = peripheralBus_dataRead;
                    end else begin
                        error_d = 1'b1;
                        rdata_d = 32'd0;
                    end
                end else if (counter_q == TIMEOUT_LAST) begin
                    state_d = RESPOND;
                    error_d = 1'b1;
                    rdata_d = 32'd0;
                end else begin
                    counter_d = counter_q + 8'd1;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            counter_q <= 8'd0;
            we_q      <= 1'b0;
            address_q <= '0;
            sel_q     <= 4'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            ack_q     <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            we_q      <= we_d;
            address_q <= address_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            error_q   <= error_d;
        end
    end

    // Strobes follow the state directly so an abort drops them on the following cycle.
    assign peripheralBus_we         = (state_q == ACCESS) &&  we_q;
    assign peripheralBus_oe         = (state_q == ACCESS) && !we_q;
    assign peripheralBus_address    = address_q;
    assign peripheralBus_byteSelect = sel_q;
    assign peripheralBus_dataWrite  = wdata_q;
    assign wb_ack_o                 = ack_q;
    assign wb_error_o               = error_q;
    assign wb_data_o                = rdata_q;

endmodule

// File: tb/tb_wb_peripheral_bridge.sv
// Self-checking bench for wb_peripheral_bridge: table of single transactions plus
// hand-written abort, reset-in-access and back-to-back sequences.
module tb_wb_peripheral_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [23:0] wb_adr_i;
    logic [31:0] wb_data_i;
    logic        wb_ack_o, wb_error_o;
    logic [31:0] wb_data_o;
    logic        pb_we, pb_oe;
    logic [23:0] pb_address;
    logic [3:0]  pb_sel;
    logic [31:0] pb_wdata;
    logic        pb_busy;
    logic [31:0] pb_rdata;
    logic        request_output;

    int tests_run    = 0;
    int tests_failed = 0;

    wb_peripheral_bridge #(.ADDRESS_WIDTH(24), .TIMEOUT_CYCLES(16)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .wb_cyc_i                 (wb_cyc_i),
        .wb_stb_i                 (wb_stb_i),
        .wb_we_i                  (wb_we_i),
        .wb_sel_i                 (wb_sel_i),
        .wb_adr_i                 (wb_adr_i),
        .wb_data_i                (wb_data_i),
        .wb_ack_o                 (wb_ack_o),
        .wb_error_o               (wb_error_o),
        .wb_data_o                (wb_data_o),
        .peripheralBus_we         (pb_we),
        .peripheralBus_oe         (pb_oe),
        .peripheralBus_address    (pb_address),
        .peripheralBus_byteSelect (pb_sel),
        .peripheralBus_dataWrite  (pb_wdata),
        .peripheralBus_busy       (pb_busy),
        .peripheralBus_dataRead   (pb_rdata),
        .requestOutput            (request_output)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [23:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          busy_cycles;
        logic        req_out;
        logic [31:0] rdata;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_strobes;
    } vec_t;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request, plays a responder that stays busy for busy_cycles strobe cycles,
    // then checks strobe count, stability, termination kind, latency and data hold.
    task automatic apply_stimulus(input vec_t v, input string name);
        int   strobes    = 0;
        int   term_cycle = 0;
        logic term_seen  = 1'b0;
        logic wrong      = 1'b0;
        logic unstable   = 1'b0;
        logic got_ack    = 1'b0;
        logic got_err    = 1'b0;
        logic [31:0] got_data = 32'd0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = v.we;
        wb_adr_i = v.adr; wb_sel_i = v.sel; wb_data_i = v.wdata;
        request_output = v.req_out; pb_rdata = v.rdata; pb_busy = 1'b0;
        for (int c = 1; c <= 40 && !term_seen; c++) begin
            tick();
            if (v.we ? pb_oe : pb_we) wrong = 1'b1;
            if (v.we ? pb_we : pb_oe) begin
                strobes++;
                if (pb_address !== v.adr || pb_sel !== v.sel || pb_wdata !== v.wdata) unstable = 1'b1;
                pb_busy = (strobes <= v.busy_cycles);
            end else begin
                pb_busy = 1'b0;
            end
            if (wb_ack_o || wb_error_o) begin
                term_seen = 1'b1; term_cycle = c;
                got_ack = wb_ack_o; got_err = wb_error_o; got_data = wb_data_o;
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            end
        end
        check_output({name, " terminated"}, 32'(term_seen), 32'd1);
        check_output({name, " strobe cycles"}, 32'(strobes), 32'(v.exp_strobes));
        check_output({name, " wrong strobe"}, 32'(wrong), 32'd0);
        check_output({name, " request stable"}, 32'(unstable), 32'd0);
        check_output({name, " ack"}, 32'(got_ack), 32'(v.exp_ack));
        check_output({name, " error"}, 32'(got_err), 32'(v.exp_err));
        check_output({name, " data"}, got_data, v.exp_data);
        check_output({name, " latency"}, 32'(term_cycle), 32'(v.exp_strobes + 1));
        tick();
        check_output({name, " one-cycle term"}, 32'(wb_ack_o | wb_error_o), 32'd0);
        check_output({name, " data held"}, wb_data_o, v.exp_data);
    endtask

    vec_t vecs[8];

    initial begin
        int   strobes;
        int   seen;
        int   acks;
        int   first_ack;
        int   second_strobe;
        int   second_ack;

        //  we  adr          sel   wdata         busy req rdata         ack err exp_data      strobes
        vecs[0] = '{1'b1, 24'h000104, 4'hF, 32'hDEADBEEF, 0,   1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1};
        vecs[1] = '{1'b0, 24'h000200, 4'hF, 32'h0,        0,   1'b1, 32'h12345678, 1'b1, 1'b0, 32'h12345678, 1};
        vecs[2] = '{1'b0, 24'h000204, 4'hF, 32'h0,        0,   1'b0, 32'h77777777, 1'b0, 1'b1, 32'h0,        1};
        vecs[3] = '{1'b0, 24'h000208, 4'h3, 32'h0,        3,   1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 32'hCAFEF00D, 4};
        vecs[4] = '{1'b1, 24'hFFFFFC, 4'h0, 32'h01020304, 1,   1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0,        2};
        vecs[5] = '{1'b0, 24'h00020C, 4'hF, 32'h0,        255, 1'b1, 32'h0BADC0DE, 1'b0, 1'b1, 32'h0,        16};
        vecs[6] = '{1'b1, 24'h000010, 4'h1, 32'hA5A5A5A5, 255, 1'b1, 32'h0,        1'b0, 1'b1, 32'h0,        16};
        vecs[7] = '{1'b0, 24'h000300, 4'hC, 32'h0,        14,  1'b1, 32'h87654321, 1'b1, 1'b0, 32'h87654321, 15};

        rst = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_sel_i = 4'h0;
        wb_adr_i = 24'h0; wb_data_i = 32'h0;
        pb_busy = 1'b0; pb_rdata = 32'h0; request_output = 1'b0;
        tick();
        tick();
        check_output("reset ack", 32'(wb_ack_o), 32'd0);
        check_output("reset error", 32'(wb_error_o), 32'd0);
        check_output("reset data", wb_data_o, 32'd0);
        check_output("reset we", 32'(pb_we), 32'd0);
        check_output("reset oe", 32'(pb_oe), 32'd0);
        check_output("reset address", 32'(pb_address), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort: drop cyc during the second busy strobe cycle.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 24'h000400;
        wb_sel_i = 4'hF; request_output = 1'b1; pb_rdata = 32'h11112222; pb_busy = 1'b1;
        strobes = 0; seen = 0;
        for (int c = 0; c < 10 && strobes < 2; c++) begin
            tick();
            if (pb_oe) strobes++;
            if (wb_ack_o || wb_error_o) seen++;
        end
        check_output("abort reached 2nd busy cycle", 32'(strobes), 32'd2);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();
        check_output("abort strobe dropped", 32'(pb_oe), 32'd0);
        for (int c = 0; c < 4; c++) begin
            if (wb_ack_o || wb_error_o || pb_oe || pb_we) seen++;
            tick();
        end
        check_output("abort no termination", 32'(seen), 32'd0);
        check_output("abort data held", wb_data_o, 32'h87654321);
        pb_busy = 1'b0;

        // Reset while the write strobe is active.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 24'h0ABCDE;
        wb_sel_i = 4'h3; wb_data_i = 32'h55AA55AA; pb_busy = 1'b1;
        tick();
        check_output("rst-access strobe on", 32'(pb_we), 32'd1);
        rst = 1'b1;
        tick();
        check_output("rst-access we", 32'(pb_we), 32'd0);
        check_output("rst-access address", 32'(pb_address), 32'd0);
        check_output("rst-access sel", 32'(pb_sel), 32'd0);
        check_output("rst-access wdata", pb_wdata, 32'd0);
        check_output("rst-access ack/err", 32'(wb_ack_o | wb_error_o), 32'd0);
        rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; pb_busy = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (wb_ack_o || wb_error_o || pb_we || pb_oe) seen++;
        end
        check_output("rst-access no termination", 32'(seen), 32'd0);

        // Back-to-back reads with cyc/stb held through the first ack.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 24'h000200;
        wb_sel_i = 4'hF; request_output = 1'b1; pb_rdata = 32'hA5A50001; pb_busy = 1'b0;
        strobes = 0; acks = 0; first_ack = 0; second_strobe = 0; second_ack = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (pb_oe) begin
                strobes++;
                if (strobes == 2) second_strobe = c;
            end
            if (wb_ack_o) begin
                acks++;
                if (acks == 1) first_ack = c;
                if (acks == 2) begin
                    second_ack = c;
                    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
                end
            end
        end
        check_output("b2b strobes", 32'(strobes), 32'd2);
        check_output("b2b acks", 32'(acks), 32'd2);
        check_output("b2b first ack", 32'(first_ack), 32'd2);
        check_output("b2b second strobe", 32'(second_strobe), 32'd4);
        check_output("b2b second ack", 32'(second_ack), 32'd5);
        check_output("b2b data", wb_data_o, 32'hA5A50001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
